// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared widths, pattern-mode codes, colour-bar table, the pixel control
// record that travels down the delay line, and the pattern selector used by
// the pixel pipeline.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int X_W     = 8;
    localparam int Y_W     = 10;
    localparam int ADDR_W  = 14;
    localparam int COLOR_W = 6;

    localparam logic [1:0] MODE_ROM   = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_SOLID = 2'd3;

    // Eight vertical bars, 32 pixels wide, indexed by x[7:5]
    localparam logic [COLOR_W-1:0] BAR_LUT [8] = '{
        6'h3F, 6'h30, 6'h0C, 6'h03, 6'h3C, 6'h33, 6'h0F, 6'h00
    };

    // Timing/position information that must stay aligned with the ROM data
    typedef struct packed {
        logic           hsync;
        logic           vsync;
        logic           blank;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_ctl_t;

    // Chooses the 2-2-2 pixel for the given mode from the aligned x/y
    function automatic logic [COLOR_W-1:0] select_pixel(
        input logic [1:0]         mode,
        input logic [COLOR_W-1:0] rom_q,
        input logic [X_W-1:0]     x,
        input logic [Y_W-1:0]     y,
        input logic [7:0]         frame_cnt
    );
        logic [COLOR_W-1:0] pix;
        case (mode)
            MODE_ROM:   pix = rom_q;
            MODE_BARS:  pix = BAR_LUT[x[7:5]];
            MODE_CHECK: pix = (x[4] ^ y[4]) ? 6'h3F : 6'h00;
            MODE_SOLID: pix = frame_cnt[7:2];
            default:    pix = 6'h00;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a press/release debounce FSM. Emits a
// single-cycle registered pulse when a press has been stable for DEBOUNCE
// cycles.
// Ports:
//   i_clk          clock
//   i_reset        synchronous active-high reset
//   i_btn_n        raw asynchronous pushbutton, active low
//   o_press_pulse  one-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE = 10000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_n,
    output logic o_press_pulse
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT = 2'd1;
    localparam logic [1:0] S_HELD       = 2'd2;
    localparam logic [1:0] S_REL_WAIT   = 2'd3;

    logic             r_sync_q1;
    logic             r_sync_q2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pulse_nxt;

    // Synchronise the raw button into the clock domain (idle level is high)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync_q1 <= 1'b1;
            r_sync_q2 <= 1'b1;
        end else begin
            r_sync_q1 <= i_btn_n;
            r_sync_q2 <= r_sync_q1;
        end
    end

    // Debounce next-state logic. The counter is loaded with one on entry to a
    // wait state because the entering cycle already saw the new level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_sync_q2) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            S_PRESS_WAIT: begin
                if (r_sync_q2) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = CNT_ZERO;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_HELD: begin
                if (r_sync_q2) begin
                    w_state_nxt = S_REL_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            S_REL_WAIT: begin
                if (!r_sync_q2) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Debounce state, counter and press pulse registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    assign o_press_pulse = r_pulse;

endmodule

// File: rtl/vga_pixel_pipe.sv
// ---------------------------------------------------------------------------
// vga_pixel_pipe
// Pixel stage between the sync generators and the PMOD VGA. Registers the
// image ROM address, delays sync/blank/x/y to match the ROM read latency,
// picks ROM data or a test pattern, blanks, and registers RGB and syncs.
// The pattern mode advances on a debounced button and is only applied at the
// start of a frame (vsync becoming active).
// Ports:
//   i_clk, i_reset                      pixel clock, synchronous active-high reset
//   i_x_counter, i_y_counter            pixel position from timing generators
//   i_hsync_in, i_vsync_in, i_blank_in  raw timing (syncs in SYNC_POL polarity)
//   o_rom_addr / i_rom_q                image ROM address (registered) / data
//   i_mode_btn_n                        raw mode pushbutton, active low
//   o_vga_red/grn/blu                   2-bit colour, zero while blanked
//   o_hsync_out, o_vsync_out            syncs aligned with the colour output
//   o_mode, o_frame_cnt                 applied pattern mode, frame counter
// Input-to-output latency is ROM_LATENCY+2 cycles for colour and syncs.
// ---------------------------------------------------------------------------
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int   ROM_LATENCY = 1,
    parameter int   DEBOUNCE    = 10000,
    parameter logic SYNC_POL    = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [X_W-1:0]    i_x_counter,
    input  logic [Y_W-1:0]    i_y_counter,
    input  logic              i_hsync_in,
    input  logic              i_vsync_in,
    input  logic              i_blank_in,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [COLOR_W-1:0] i_rom_q,
    input  logic              i_mode_btn_n,
    output logic [1:0]        o_vga_red,
    output logic [1:0]        o_vga_grn,
    output logic [1:0]        o_vga_blu,
    output logic              o_hsync_out,
    output logic              o_vsync_out,
    output logic [1:0]        o_mode,
    output logic [7:0]        o_frame_cnt
);

    localparam logic SYNC_IDLE = ~SYNC_POL;

    // Contents of the delay line after reset: blanked, syncs inactive
    localparam pix_ctl_t IDLE_CTL = '{
        hsync: SYNC_IDLE, vsync: SYNC_IDLE, blank: 1'b1, x: '0, y: '0
    };

    logic [ADDR_W-1:0]  r_rom_addr;
    pix_ctl_t           r_dly [ROM_LATENCY+1];
    logic [COLOR_W-1:0] r_rgb;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_vsync_prev;
    logic [7:0]         r_frame_cnt;
    logic [1:0]         r_mode;
    logic [1:0]         r_pending;

    pix_ctl_t           w_ctl_in;
    pix_ctl_t           w_tail;
    logic [COLOR_W-1:0] w_pix;
    logic               w_frame_edge;
    logic               w_press;

    assign w_ctl_in = '{
        hsync: i_hsync_in, vsync: i_vsync_in, blank: i_blank_in,
        x: i_x_counter, y: i_y_counter
    };

    // The last delay stage lines up with i_rom_q for the same pixel
    assign w_tail       = r_dly[ROM_LATENCY];
    assign w_pix        = select_pixel(r_mode, i_rom_q, w_tail.x, w_tail.y, r_frame_cnt);
    assign w_frame_edge = (i_vsync_in == SYNC_POL) && (r_vsync_prev != SYNC_POL);

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_btn (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_btn_n       (i_mode_btn_n),
        .o_press_pulse (w_press)
    );

    // Stage 0 ROM address register and the control delay line
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rom_addr <= '0;
            for (int i = 0; i <= ROM_LATENCY; i++) begin
                r_dly[i] <= IDLE_CTL;
            end
        end else begin
            // 128x128 image: each ROM pixel covers 2 columns and 8 lines
            r_rom_addr <= {i_y_counter[9:3], i_x_counter[7:1]};
            r_dly[0]   <= w_ctl_in;
            for (int i = 1; i <= ROM_LATENCY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Output register: blanking overrides every pattern
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rgb   <= 6'h00;
            r_hsync <= SYNC_IDLE;
            r_vsync <= SYNC_IDLE;
        end else begin
            r_rgb   <= w_tail.blank ? 6'h00 : w_pix;
            r_hsync <= w_tail.hsync;
            r_vsync <= w_tail.vsync;
        end
    end

    // Frame counter, pending mode and applied mode. At a frame edge the mode
    // takes the pending value as it stood before any same-cycle press.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vsync_prev <= SYNC_IDLE;
            r_frame_cnt  <= 8'h00;
            r_mode       <= MODE_ROM;
            r_pending    <= MODE_ROM;
        end else begin
            r_vsync_prev <= i_vsync_in;
            if (w_frame_edge) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_mode      <= r_pending;
            end else begin
                r_frame_cnt <= r_frame_cnt;
                r_mode      <= r_mode;
            end
            if (w_press) begin
                r_pending <= r_pending + 2'd1;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_vga_red   = r_rgb[5:4];
    assign o_vga_grn   = r_rgb[3:2];
    assign o_vga_blu   = r_rgb[1:0];
    assign o_hsync_out = r_hsync;
    assign o_vsync_out = r_vsync;
    assign o_mode      = r_mode;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_pipe
// Directed bench for vga_pixel_pipe with a latency-1 ROM model whose data is
// rom_addr[5:0]. Expected pixels are queued when driven and compared when
// they are due at the output. DEBOUNCE is shortened to keep runs brief.
// ---------------------------------------------------------------------------
module tb_vga_pixel_pipe;

    localparam int D   = 64;
    localparam int LAT = 3;

    typedef struct {
        int         due;
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  x;
    logic [9:0]  y;
    logic        hs, vs, blank;
    logic [13:0] rom_addr;
    logic [5:0]  rom_q;
    logic        btn_n;
    logic [1:0]  red, grn, blu;
    logic        hs_o, vs_o;
    logic [1:0]  mode;
    logic [7:0]  frame;

    exp_t        sb[$];
    exp_t        cur;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [1:0]  exp_mode = 2'd0;
    logic [1:0]  exp_pending = 2'd0;
    logic [7:0]  exp_frame = 8'd0;

    vga_pixel_pipe #(
        .ROM_LATENCY (1),
        .DEBOUNCE    (D),
        .SYNC_POL    (1'b0)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_x_counter  (x),
        .i_y_counter  (y),
        .i_hsync_in   (hs),
        .i_vsync_in   (vs),
        .i_blank_in   (blank),
        .o_rom_addr   (rom_addr),
        .i_rom_q      (rom_q),
        .i_mode_btn_n (btn_n),
        .o_vga_red    (red),
        .o_vga_grn    (grn),
        .o_vga_blu    (blu),
        .o_hsync_out  (hs_o),
        .o_vsync_out  (vs_o),
        .o_mode       (mode),
        .o_frame_cnt  (frame)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model, one cycle read latency
    always @(posedge clk) rom_q <= rom_addr[5:0];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [5:0] exp_pix(input logic [1:0] m, input logic [7:0] px,
                                           input logic [9:0] py, input logic [7:0] f);
        logic [13:0] a;
        a = {py[9:3], px[7:1]};
        case (m)
            2'd0: return a[5:0];
            2'd1: begin
                case (px[7:5])
                    3'd0: return 6'h3F;
                    3'd1: return 6'h30;
                    3'd2: return 6'h0C;
                    3'd3: return 6'h03;
                    3'd4: return 6'h3C;
                    3'd5: return 6'h33;
                    3'd6: return 6'h0F;
                    default: return 6'h00;
                endcase
            end
            2'd2: return (px[4] ^ py[4]) ? 6'h3F : 6'h00;
            default: return f[7:2];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock, then retire any scoreboard entries now due
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            chk("pix", {24'h0, red, grn, blu, hs_o, vs_o}, {24'h0, cur.rgb, cur.hs, cur.vs});
        end
    endtask

    task automatic drive_pix(input logic [7:0] px, input logic [9:0] py,
                             input logic phs, input logic pbl);
        exp_t e;
        x = px; y = py; hs = phs; vs = 1'b1; blank = pbl;
        e.due = cyc + LAT;
        e.rgb = pbl ? 6'h00 : exp_pix(exp_mode, px, py, exp_frame);
        e.hs  = phs;
        e.vs  = 1'b1;
        sb.push_back(e);
        tick();
    endtask

    task automatic vsync_fall();
        repeat (3) tick();
        vs = 1'b0;
        tick();
        exp_frame = exp_frame + 8'd1;
        exp_mode  = exp_pending;
        chk("frame_cnt", frame, exp_frame);
        chk("mode_at_frame", mode, exp_mode);
        vs = 1'b1;
        tick();
    endtask

    task automatic press(input int len);
        btn_n = 1'b0;
        repeat (len) tick();
        btn_n = 1'b1;
        repeat (D + 8) tick();
        if (len >= D) exp_pending = exp_pending + 2'd1;
    endtask

    initial begin
        reset = 1'b1; x = 8'h00; y = 10'h000; hs = 1'b1; vs = 1'b1; blank = 1'b1;
        btn_n = 1'b1;
        repeat (4) tick();
        chk("rst_rgb", {red, grn, blu}, 6'h00);
        chk("rst_hs", hs_o, 1'b1);
        chk("rst_vs", vs_o, 1'b1);
        chk("rst_mode", mode, 2'd0);
        chk("rst_frame", frame, 8'd0);
        chk("rst_addr", rom_addr, 14'h0000);
        reset = 1'b0;
        tick();

        // ROM path: address one cycle later, pixel three cycles later
        drive_pix(8'h25, 10'h1A8, 1'b1, 1'b0);
        chk("rom_addr", rom_addr, 14'h1A92);
        for (int i = 0; i < 8; i++) begin
            drive_pix(8'(i * 8'h13 + 8'h07), 10'(i * 37 + 5), 1'b1, 1'b0);
        end

        // Single hsync pulse plus a blank pulse in the same window
        for (int i = 0; i < 8; i++) begin
            drive_pix(8'(8'h40 + i * 2), 10'h021, (i == 3) ? 1'b0 : 1'b1,
                      (i == 3 || i == 4) ? 1'b1 : 1'b0);
        end

        // Press one cycle short of the debounce time: ignored
        press(D - 1);
        vsync_fall();
        chk("short_press_mode", mode, 2'd0);

        // Full-length press: pending only, mode waits for the frame edge
        press(D);
        chk("mode_before_vsync", mode, 2'd0);
        vsync_fall();
        chk("mode_after_vsync", mode, 2'd1);

        // Colour bars
        drive_pix(8'h40, 10'h010, 1'b1, 1'b0);
        drive_pix(8'h00, 10'h010, 1'b1, 1'b0);
        drive_pix(8'hA3, 10'h010, 1'b1, 1'b0);
        drive_pix(8'hE1, 10'h010, 1'b1, 1'b1);

        // Checker
        press(D);
        vsync_fall();
        drive_pix(8'h10, 10'h000, 1'b1, 1'b0);
        drive_pix(8'h10, 10'h010, 1'b1, 1'b0);
        drive_pix(8'h05, 10'h013, 1'b1, 1'b0);

        // Solid colour from frame counter
        press(D);
        vsync_fall();
        drive_pix(8'h77, 10'h123, 1'b1, 1'b0);
        drive_pix(8'h00, 10'h000, 1'b1, 1'b1);

        // Back to ROM
        press(D);
        vsync_fall();
        drive_pix(8'h3C, 10'h0F0, 1'b1, 1'b0);

        // Two presses in one frame accumulate
        press(D);
        press(D);
        chk("accum_before_vsync", mode, 2'd0);
        vsync_fall();
        chk("accum_mode", mode, 2'd2);

        // Frame counter wrap
        for (int i = 0; i < 256; i++) begin
            vsync_fall();
        end
        chk("frame_full_wrap", frame, exp_frame);
        while (exp_frame != 8'd0) vsync_fall();
        chk("frame_wrap_zero", frame, 8'd0);

        // Reset mid-line with live pixels in flight
        repeat (4) tick();
        x = 8'h25; y = 10'h1A8; blank = 1'b0; hs = 1'b0; vs = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_mode = 2'd0; exp_pending = 2'd0; exp_frame = 8'd0;
        chk("mid_rst_rgb", {red, grn, blu}, 6'h00);
        chk("mid_rst_hs", hs_o, 1'b1);
        chk("mid_rst_vs", vs_o, 1'b1);
        chk("mid_rst_mode", mode, 2'd0);
        chk("mid_rst_frame", frame, 8'd0);
        chk("mid_rst_addr", rom_addr, 14'h0000);
        tick();
        chk("post_rst_blank1", {red, grn, blu, hs_o}, 7'b0000001);
        tick();
        chk("post_rst_blank2", {red, grn, blu, hs_o}, 7'b0000001);
        tick();
        chk("post_rst_real", {red, grn, blu, hs_o}, {6'h12, 1'b0});

        repeat (5) tick();
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
